// File: rtl/pkt_rx_pkg.sv
// Shared types, defaults and the footer function for the UART packet loader.
package pkt_rx_pkg;

  localparam logic [2:0] HDR_DEFAULT = 3'b101;
  localparam int unsigned FOOT_MAX_W = 32;

  typedef enum logic [1:0] {
    StHunt,
    StCollect,
    StCheck,
    StWrite
  } ldr_state_e;

  typedef enum logic [2:0] {
    RxWaitHigh,
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  // f[2] = parity of data, f[1] = parity of loc, f[0] = parity of both upper halves.
  function automatic logic [2:0] calc_footer(input logic [FOOT_MAX_W-1:0] data,
                                             input int unsigned data_w,
                                             input logic [FOOT_MAX_W-1:0] loc,
                                             input int unsigned loc_w);
    logic [2:0] f;
    f = '0;
    for (int unsigned i = 0; i < FOOT_MAX_W; i++) begin
      if (i < data_w) f[2] = f[2] ^ data[i];
      if (i < loc_w) f[1] = f[1] ^ loc[i];
      if (i >= data_w / 2 && i < data_w) f[0] = f[0] ^ data[i];
      if (i >= loc_w / 2 && i < loc_w) f[0] = f[0] ^ loc[i];
    end
    return f;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, stop-bit framing check.
module uart_rx_byte
  import pkt_rx_pkg::*;
#(
  parameter int unsigned FREQ = 50_000_000,
  parameter int unsigned BAUD = 312_500
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);

  localparam int unsigned ClksPerBit = FREQ / BAUD;
  localparam logic [15:0] LastCnt = 16'(ClksPerBit - 1);
  localparam logic [15:0] HalfCnt = 16'(ClksPerBit / 2 - 1);

  logic [1:0]  sync_q;
  logic        rx_s;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        valid_q, valid_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      state_q <= RxWaitHigh;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    unique case (state_q)
      RxWaitHigh: if (rx_s) state_d = RxIdle;
      RxIdle: begin
        if (!rx_s) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is gone by mid-bit was a glitch.
          state_d = rx_s ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RxData: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (idx_q == 3'd7) state_d = RxStop;
          else idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RxStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = RxIdle;
          end else begin
            // Framing error: drop the byte and wait for the line to go idle again.
            state_d = RxWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = RxWaitHigh;
    endcase
  end

  assign byte_o       = shreg_q;
  assign byte_valid_o = valid_q;

endmodule

// File: rtl/uart_packet_loader.sv
// Serial packet loader: assembles {HDR, loc, data, footer} packets and writes good ones to RAM.
// Optional inter-byte timeout in COLLECT is enabled by defining PKT_TIMEOUT_EN.
module uart_packet_loader
  import pkt_rx_pkg::*;
#(
  parameter int unsigned FREQ     = 50_000_000,
  parameter int unsigned BAUD     = 312_500,
  parameter int unsigned LOC_W    = 10,
  parameter int unsigned DATA_W   = 8,
  parameter logic [2:0]  HDR      = HDR_DEFAULT,
  parameter int unsigned NUM_PKTS = 785
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rxd_i,
  input  logic              clear_i,
  output logic              mem_we_o,
  output logic [LOC_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [31:0]       count_packets_o,
  output logic              receive_done_o,
  output logic [15:0]       hdr_err_cnt_o,
  output logic [15:0]       pkt_err_cnt_o
);

  localparam int unsigned PktW     = 6 + LOC_W + DATA_W;
  localparam int unsigned NumBytes = PktW / 8;

  logic [7:0]        rx_byte;
  logic              rx_valid;
  ldr_state_e        state_q, state_d;
  logic [PktW-1:0]   pkt_q, pkt_d;
  logic [7:0]        nbytes_q, nbytes_d;
  logic [31:0]       count_q, count_d;
  logic              done_q, done_d;
  logic [15:0]       hdr_err_q, hdr_err_d;
  logic [15:0]       pkt_err_q, pkt_err_d;
  logic              hdr_inc, pkt_inc;
  logic              timeout;
  logic [LOC_W-1:0]  loc;
  logic [DATA_W-1:0] data;
  logic [2:0]        foot, foot_exp;
  logic              pkt_ok;

  uart_rx_byte #(
    .FREQ(FREQ),
    .BAUD(BAUD)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rxd_i       (rxd_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid)
  );

  assign loc      = pkt_q[3+DATA_W +: LOC_W];
  assign data     = pkt_q[3 +: DATA_W];
  assign foot     = pkt_q[2:0];
  assign foot_exp = calc_footer(FOOT_MAX_W'(data), DATA_W, FOOT_MAX_W'(loc), LOC_W);
  assign pkt_ok   = (pkt_q[PktW-1 -: 3] == HDR) && (foot == foot_exp)
                    && (32'(loc) < NUM_PKTS);

`ifdef PKT_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = 4 * 10 * (FREQ / BAUD);

  logic [31:0] tmr_q, tmr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end

  // Counts idle cycles in COLLECT; any received byte restarts it.
  always_comb begin
    tmr_d = '0;
    if (state_q == StCollect && !rx_valid && !clear_i) tmr_d = tmr_q + 32'd1;
  end

  assign timeout = (state_q == StCollect) && !rx_valid && (tmr_q == 32'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StHunt;
      pkt_q     <= '0;
      nbytes_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      hdr_err_q <= '0;
      pkt_err_q <= '0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      nbytes_q  <= nbytes_d;
      count_q   <= count_d;
      done_q    <= done_d;
      hdr_err_q <= hdr_err_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    nbytes_d = nbytes_q;
    count_d  = count_q;
    done_d   = done_q;
    hdr_inc  = 1'b0;
    pkt_inc  = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (rx_valid) begin
          if (rx_byte[7:5] == HDR) begin
            pkt_d    = {pkt_q[PktW-9:0], rx_byte};
            nbytes_d = 8'd1;
            state_d  = StCollect;
          end else begin
            hdr_inc = 1'b1;
          end
        end
      end
      StCollect: begin
        if (rx_valid) begin
          pkt_d    = {pkt_q[PktW-9:0], rx_byte};
          nbytes_d = nbytes_q + 8'd1;
          if (nbytes_q == 8'(NumBytes - 1)) state_d = StCheck;
        end else if (timeout) begin
          pkt_inc = 1'b1;
          state_d = StHunt;
        end
      end
      StCheck: begin
        if (pkt_ok) begin
          state_d = StWrite;
        end else begin
          pkt_inc = 1'b1;
          state_d = StHunt;
        end
      end
      StWrite: begin
        count_d = count_q + 32'd1;
        if (count_d == NUM_PKTS) done_d = 1'b1;
        state_d = StHunt;
      end
      default: state_d = StHunt;
    endcase

    // Clear wins over everything except the RAM strobe of a WRITE already in progress.
    if (clear_i) begin
      state_d  = StHunt;
      nbytes_d = '0;
      count_d  = '0;
      done_d   = 1'b0;
      hdr_inc  = 1'b0;
      pkt_inc  = 1'b0;
    end
  end

  assign hdr_err_d = (hdr_inc && hdr_err_q != 16'hFFFF) ? hdr_err_q + 16'd1 : hdr_err_q;
  assign pkt_err_d = (pkt_inc && pkt_err_q != 16'hFFFF) ? pkt_err_q + 16'd1 : pkt_err_q;

  assign mem_we_o        = (state_q == StWrite);
  assign mem_addr_o      = loc;
  assign mem_wdata_o     = data;
  assign count_packets_o = count_q;
  assign receive_done_o  = done_q;
  assign hdr_err_cnt_o   = hdr_err_q;
  assign pkt_err_cnt_o   = pkt_err_q;

endmodule

// File: tb/tb_uart_packet_loader.sv
// Self-checking bench for uart_packet_loader against a byte-stream level reference model.
module tb_uart_packet_loader;

  localparam int unsigned FREQ   = 8;
  localparam int unsigned BAUD   = 1;
  localparam int unsigned CPB    = FREQ / BAUD;
  localparam int unsigned LOC_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam logic [2:0]  HDR    = 3'b101;
  localparam int unsigned NUM    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rxd = 1'b0;
  logic              clear = 1'b0;
  logic              mem_we;
  logic [LOC_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [31:0]       count_packets;
  logic              receive_done;
  logic [15:0]       hdr_err_cnt;
  logic [15:0]       pkt_err_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  pend[$];
  logic [17:0] exp_wr[$];
  logic [17:0] got_wr[$];
  int unsigned exp_cnt = 0;
  logic        exp_done = 1'b0;
  int unsigned exp_hdr = 0;
  int unsigned exp_pkt = 0;

  uart_packet_loader #(
    .FREQ    (FREQ),
    .BAUD    (BAUD),
    .LOC_W   (LOC_W),
    .DATA_W  (DATA_W),
    .HDR     (HDR),
    .NUM_PKTS(NUM)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rxd_i          (rxd),
    .clear_i        (clear),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .count_packets_o(count_packets),
    .receive_done_o (receive_done),
    .hdr_err_cnt_o  (hdr_err_cnt),
    .pkt_err_cnt_o  (pkt_err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) got_wr.push_back({mem_addr, mem_wdata});

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_footer(input logic [9:0] l, input logic [7:0] d);
    return {^d, ^l, ^{d[7:4], l[9:5]}};
  endfunction

  function automatic logic [23:0] make_pkt(input logic [9:0] l, input logic [7:0] d,
                                           input logic [2:0] flip);
    return {HDR, l, d, ref_footer(l, d) ^ flip};
  endfunction

  // Model: consumes one correctly framed byte.
  task automatic model_byte(input logic [7:0] b);
    logic [23:0] p;
    if (pend.size() == 0 && b[7:5] != HDR) begin
      exp_hdr++;
    end else begin
      pend.push_back(b);
      if (pend.size() == 3) begin
        p = {pend[0], pend[1], pend[2]};
        pend.delete();
        if (p[2:0] == ref_footer(p[20:11], p[10:3]) && p[20:11] < NUM) begin
          exp_wr.push_back({p[20:11], p[10:3]});
          exp_cnt++;
          if (exp_cnt == NUM) exp_done = 1'b1;
        end else begin
          exp_pkt++;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_model(input logic [7:0] b);
    model_byte(b);
    send_byte(b, 1'b1);
  endtask

  task automatic send_pkt(input logic [9:0] l, input logic [7:0] d, input logic [2:0] flip);
    logic [23:0] p;
    p = make_pkt(l, d, flip);
    send_model(p[23:16]);
    send_model(p[15:8]);
    send_model(p[7:0]);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (3 * CPB) @(negedge clk);
    check({tag, ".count"}, 64'(count_packets), 64'(exp_cnt));
    check({tag, ".done"}, 64'(receive_done), 64'(exp_done));
    check({tag, ".hdr_err"}, 64'(hdr_err_cnt), 64'(exp_hdr));
    check({tag, ".pkt_err"}, 64'(pkt_err_cnt), 64'(exp_pkt));
    check({tag, ".nwrites"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    while (got_wr.size() > 0 && exp_wr.size() > 0)
      check({tag, ".write"}, 64'(got_wr.pop_front()), 64'(exp_wr.pop_front()));
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    pend.delete();
    exp_cnt  = 0;
    exp_done = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [23:0] p;
    int unsigned r;

    // Reset values, with rxd held low from reset
    repeat (3) @(negedge clk);
    check("reset.mem_we", 64'(mem_we), 64'd0);
    check("reset.addr", 64'(mem_addr), 64'd0);
    check("reset.wdata", 64'(mem_wdata), 64'd0);
    check("reset.count", 64'(count_packets), 64'd0);
    check("reset.done", 64'(receive_done), 64'd0);
    check("reset.hdr_err", 64'(hdr_err_cnt), 64'd0);
    check("reset.pkt_err", 64'(pkt_err_cnt), 64'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    send_pkt(10'd7, 8'h3C, 3'b000);
    settle_and_check("idle_low");

    // Garbage header byte then a good packet
    send_model(8'h00);
    send_pkt(10'd5, 8'hA7, 3'b000);
    settle_and_check("hdr_slip");

    // Footer bit 2 inverted
    send_pkt(10'd3, 8'h55, 3'b100);
    settle_and_check("bad_footer");

    // Location out of range, then a good packet
    send_pkt(10'd900, 8'h11, 3'b000);
    send_pkt(10'd9, 8'hF0, 3'b000);
    settle_and_check("bad_loc");

    // Framing error byte is ignored entirely
    send_byte(8'hA5, 1'b0);
    send_pkt(10'd2, 8'h81, 3'b000);
    settle_and_check("framing");

    // Clear mid-packet aborts the partial packet
    p = make_pkt(10'd4, 8'h42, 3'b000);
    send_byte(p[23:16], 1'b1);
    pulse_clear();
    send_pkt(10'd4, 8'h42, 3'b000);
    settle_and_check("clear_abort");

`ifdef PKT_TIMEOUT_EN
    p = make_pkt(10'd6, 8'h66, 3'b000);
    send_byte(p[23:16], 1'b1);
    send_byte(p[15:8], 1'b1);
    repeat (4 * 10 * CPB + 20) @(negedge clk);
    exp_pkt++;
    send_pkt(10'd6, 8'h66, 3'b000);
    settle_and_check("timeout");
`endif

    // Randomised mix of good, bad-footer, garbage and misframed bytes
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        b = 8'($urandom);
        if (b[7:5] == HDR) b[7:5] = 3'b000;
        send_model(b);
      end else if (r == 1) begin
        send_pkt(10'($urandom_range(0, NUM - 1)), 8'($urandom), 3'($urandom_range(1, 7)));
      end else if (r == 2) begin
        send_byte(8'($urandom), 1'b0);
      end else begin
        send_pkt(10'($urandom_range(0, NUM - 1)), 8'($urandom), 3'b000);
      end
    end
    settle_and_check("random");

    pulse_clear();
    settle_and_check("clear");

    // Full load: locations 0..NUM-1, done sets exactly on the last one
    for (int l = 0; l < NUM; l++) begin
      send_pkt(10'(l), 8'($urandom), 3'b000);
      if (l == NUM - 2) settle_and_check("load_pre");
    end
    settle_and_check("load_done");

    // Duplicate location after done still writes and counts
    send_pkt(10'd0, 8'h99, 3'b000);
    settle_and_check("dup");

    // Asynchronous reset mid-packet
    p = make_pkt(10'd1, 8'h01, 3'b000);
    send_byte(p[23:16], 1'b1);
    #3 rst = 1'b1;
    #1;
    check("arst.count", 64'(count_packets), 64'd0);
    check("arst.done", 64'(receive_done), 64'd0);
    check("arst.hdr_err", 64'(hdr_err_cnt), 64'd0);
    check("arst.pkt_err", 64'(pkt_err_cnt), 64'd0);
    @(negedge clk) rst = 1'b0;
    pend.delete();
    exp_cnt  = 0;
    exp_done = 1'b0;
    exp_hdr  = 0;
    exp_pkt  = 0;
    repeat (CPB) @(negedge clk);
    send_pkt(10'd8, 8'hC3, 3'b000);
    settle_and_check("after_arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
